branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning PC/target width in bits.
REQ-002 SHALL have parameter IDX_W, default 6, meaning table index width (2**IDX_W entries, indexed by pc[IDX_W+1:2]).
REQ-003 SHALL have parameter TAG_W, default ADDR_W-IDX_W-2, meaning stored tag width (pc[ADDR_W-1:IDX_W+2]).
REQ-004 SHALL have parameter CNT_W, default 2, meaning saturating-counter width per entry.
REQ-005 SHALL have port clk_i, input, 1, meaning the single rising-edge clock.
REQ-006 SHALL have port rst_i, input, 1, meaning reset: synchronous, active-low.
REQ-007 SHALL have port flush_i, input, 1, meaning invalidate the whole table.
REQ-008 SHALL have port pc_i, input, ADDR_W, meaning IF-stage lookup PC.
REQ-009 SHALL have port hit_o, output, 1, meaning entry valid and tag match for pc_i.
REQ-010 SHALL have port pred_taken_o, output, 1, meaning hit_o AND counter MSB set.
REQ-011 SHALL have port pred_target_o, output, ADDR_W, meaning stored target when pred_taken_o, else pc_i+4.
REQ-012 SHALL have port upd_valid_i, input, 1, meaning ID-stage resolved branch/jump this cycle.
REQ-013 SHALL have port upd_pc_i, input, ADDR_W, meaning PC of the resolved instruction.
REQ-014 SHALL have port upd_taken_i, input, 1, meaning actual outcome.
REQ-015 SHALL have port upd_target_i, input, ADDR_W, meaning actual taken target.
REQ-016 SHALL have port upd_mispred_i, input, 1, meaning prediction for this update was wrong; qualified by upd_valid_i.
REQ-017 SHALL have port mispred_cnt_o, output, 32, meaning saturating count of mispredictions.

Function
REQ-018 Lookup SHALL be combinational from pc_i and current table state (zero latency); updates take effect at the next clk_i edge.
REQ-019 Same-cycle update and lookup to one index SHALL return pre-update contents (no bypass).
REQ-020 Update on hit SHALL increment the counter if upd_taken_i else decrement it, saturating at 0 and 2**CNT_W-1; target rewritten only when taken.
REQ-021 Update on miss with upd_taken_i=1 SHALL allocate/replace: valid=1, tag written, target written, counter = 2**(CNT_W-1) (weakly taken).
REQ-022 Update on miss with upd_taken_i=0 SHALL leave the table unchanged.
REQ-023 flush_i SHALL clear every valid bit in one cycle; counters, tags, targets are don't-care afterwards.
REQ-024 flush_i and upd_valid_i in the same cycle: flush wins; no allocation or counter change.
REQ-025 mispred_cnt_o SHALL increment by 1 per cycle with upd_valid_i AND upd_mispred_i, holding at 32'hFFFF_FFFF; flush_i does not clear it.
REQ-026 pc_i+4 SHALL wrap modulo 2**ADDR_W.

Reset
REQ-027 While rst_i=0 at a clk_i edge, all valid bits SHALL clear, all counters SHALL load 2**(CNT_W-1)-1 (weakly not-taken), and mispred_cnt_o SHALL load 0.
REQ-028 Updates and flushes presented while rst_i=0 SHALL be ignored; reset mid-operation discards all learned state.
REQ-029 After reset hit_o=0, pred_taken_o=0, pred_target_o=pc_i+4.

Structure
REQ-030 Default parameter values and the counter encodings (weak/strong taken/not-taken constants) SHALL live in the shared package bp_pkg.
REQ-031 Per-entry saturating counter logic SHALL be the sub-module sat_counter (parameter CNT_W; inputs inc, dec, load, load_val).
REQ-032 Table storage SHALL be flops (no memory macros).

Verification
REQ-033 Reset then pc_i=32'h0000_0040 -> hit_o=0, pred_taken_o=0, pred_target_o=32'h0000_0044.
REQ-034 Update pc=32'h40 taken target=32'h100; next cycle lookup 32'h40 -> hit_o=1, pred_taken_o=1, pred_target_o=32'h100.
REQ-035 Two not-taken updates on pc 32'h40 after allocation -> counter 0, pred_taken_o=0, hit_o=1; third not-taken keeps counter 0.
REQ-036 pc 32'h40 allocated, then taken update pc 32'h140 (same index, IDX_W=6) -> lookup 32'h40 misses, 32'h140 hits with new target.
REQ-037 flush_i=1 with upd_valid_i=1 same cycle -> all lookups miss next cycle; no new entry.
REQ-038 Force mispred_cnt_o to 32'hFFFF_FFFE, apply three mispredicts -> output holds 32'hFFFF_FFFF.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared defaults and saturating-counter encodings for the branch predictor.
// The counter helpers work for any width; the CNT2_* names cover the default 2-bit case.
package bp_pkg;

    localparam int BP_ADDR_W = 32;
    localparam int BP_IDX_W  = 6;
    localparam int BP_CNT_W  = 2;
    localparam int BP_TAG_W  = BP_ADDR_W - BP_IDX_W - 2;

    localparam logic [1:0] CNT2_STRONG_NT = 2'b00;
    localparam logic [1:0] CNT2_WEAK_NT   = 2'b01;
    localparam logic [1:0] CNT2_WEAK_T    = 2'b10;
    localparam logic [1:0] CNT2_STRONG_T  = 2'b11;

    function automatic int unsigned cnt_weak_taken(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic int unsigned cnt_weak_not_taken(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic int unsigned cnt_strong_taken(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Per-entry up/down saturating counter; load has priority over training.
// Reset leaves the counter weakly not-taken.
module sat_counter
    import bp_pkg::*;
#(
    parameter int CNT_W = BP_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(cnt_weak_not_taken(CNT_W));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= CNT_RST;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc && cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped, tagged branch target buffer with per-entry saturating counters.
// Lookup is combinational on pc_i; updates land at the next clock edge with no bypass.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ADDR_W = BP_ADDR_W,
    parameter int IDX_W  = BP_IDX_W,
    parameter int TAG_W  = ADDR_W - IDX_W - 2,
    parameter int CNT_W  = BP_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              hit_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_mispred_i,
    output logic [31:0]       mispred_cnt_o
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(cnt_weak_taken(CNT_W));

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tags    [ENTRIES];
    logic [ADDR_W-1:0]  targets [ENTRIES];
    logic [CNT_W-1:0]   cnts    [ENTRIES];
    logic [31:0]        mispred_cnt;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             upd_en;
    logic             train;
    logic             alloc;
    logic             unused_pc_bits;

    assign lk_idx  = pc_i[IDX_W+1:2];
    assign lk_tag  = pc_i[ADDR_W-1:IDX_W+2];
    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign upd_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
    assign unused_pc_bits = ^{pc_i[1:0], upd_pc_i[1:0]};

    // Flush suppresses the update entirely; reset gating lives in each flop.
    assign upd_en  = upd_valid_i && !flush_i;
    assign upd_hit = valid[upd_idx] && (tags[upd_idx] == upd_tag);
    assign train   = upd_en && upd_hit;
    assign alloc   = upd_en && !upd_hit && upd_taken_i;

    always_comb begin
        hit_o         = valid[lk_idx] && (tags[lk_idx] == lk_tag);
        pred_taken_o  = hit_o && cnts[lk_idx][CNT_W-1];
        pred_target_o = pred_taken_o ? targets[lk_idx] : pc_i + ADDR_W'(4);
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        logic sel;
        assign sel = (upd_idx == IDX_W'(g));

        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk      (clk_i),
            .rst_n    (rst_i),
            .inc      (train && sel && upd_taken_i),
            .dec      (train && sel && !upd_taken_i),
            .load     (alloc && sel),
            .load_val (CNT_ALLOC),
            .cnt      (cnts[g])
        );
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid <= '0;
        end else if (flush_i) begin
            valid <= '0;
        end else if (alloc) begin
            valid[upd_idx] <= 1'b1;
        end
    end

    // Tags and targets carry no reset: they are only observed behind a valid bit.
    always_ff @(posedge clk_i) begin
        if (rst_i && alloc) begin
            tags[upd_idx] <= upd_tag;
        end
        if (rst_i && upd_en && upd_taken_i && (upd_hit || alloc)) begin
            targets[upd_idx] <= upd_target_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mispred_cnt <= '0;
        end else if (upd_valid_i && upd_mispred_i && mispred_cnt != 32'hFFFF_FFFF) begin
            mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

    assign mispred_cnt_o = mispred_cnt;

endmodule
